// File: rtl/figure_motion_ctrl.sv
// Button-driven horizontal motion controller for the VGA figure: synchronises and
// debounces the buttons, then steps x_center once per frame with acceleration and clamping.
module figure_motion_ctrl #(
    parameter int unsigned X_INIT          = 320,
    parameter int unsigned X_MIN           = 20,
    parameter int unsigned X_MAX           = 620,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned ACCEL_FRAMES    = 8,
    parameter int unsigned MAX_SPEED       = 4,
    parameter bit          VS_ACTIVE       = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       vsync,
    output logic [9:0] x_center,
    output logic [1:0] dir,
    output logic [2:0] speed,
    output logic       at_edge,
    output logic       frame_tick
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned AW = $clog2(ACCEL_FRAMES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW-1:0] ACC_LAST = AW'(ACCEL_FRAMES);
    localparam logic [2:0]    SPD_MAX  = 3'(MAX_SPEED);
    localparam logic [10:0]   XMIN11   = 11'(X_MIN);
    localparam logic [10:0]   XMAX11   = 11'(X_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        MOVE_L = 2'b01,
        MOVE_R = 2'b10
    } state_t;

    // Index 0 = left button, index 1 = right button.
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    stab_q, stab_d;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];

    logic   vs_q, tick, frame_tick_q;
    state_t state_q, state_d, req;
    logic [2:0]    speed_q, speed_d, step, spd_base;
    logic [AW-1:0] acc_q, acc_d, acc_inc;
    logic [9:0]    x_q, x_d;
    logic [10:0]   x11, step11, x_left, x_right;

    always_comb begin
        stab_d = stab_q;
        for (int unsigned i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stab_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stab_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign tick = (vsync == VS_ACTIVE) && (vs_q != VS_ACTIVE);

    // Saturating moves are evaluated at 11 bits so neither direction can wrap.
    assign x11     = {1'b0, x_q};
    assign step11  = {8'd0, step};
    assign x_left  = (x11 < XMIN11 + step11) ? XMIN11 : x11 - step11;
    assign x_right = (x11 + step11 > XMAX11) ? XMAX11 : x11 + step11;

    always_comb begin
        state_d  = state_q;
        speed_d  = speed_q;
        acc_d    = acc_q;
        x_d      = x_q;
        step     = '0;
        spd_base = '0;
        acc_inc  = '0;
        case (stab_q)
            2'b01:   req = MOVE_L;
            2'b10:   req = MOVE_R;
            default: req = IDLE;
        endcase
        if (tick) begin
            if (req == IDLE) begin
                state_d = IDLE;
                speed_d = '0;
                acc_d   = '0;
            end else begin
                if (req == state_q) begin
                    step     = speed_q;
                    spd_base = speed_q;
                    acc_inc  = acc_q + 1'b1;
                end else begin
                    state_d  = req;
                    step     = 3'd1;
                    spd_base = 3'd1;
                    acc_inc  = AW'(1);
                end
                if (acc_inc == ACC_LAST) begin
                    acc_d   = '0;
                    speed_d = (spd_base >= SPD_MAX) ? SPD_MAX : spd_base + 3'd1;
                end else begin
                    acc_d   = acc_inc;
                    speed_d = spd_base;
                end
                x_d = (req == MOVE_L) ? 10'(x_left) : 10'(x_right);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stab_q       <= '0;
            cnt_q[0]     <= '0;
            cnt_q[1]     <= '0;
            vs_q         <= 1'b0;
            frame_tick_q <= 1'b0;
            state_q      <= IDLE;
            speed_q      <= '0;
            acc_q        <= '0;
            x_q          <= 10'(X_INIT);
        end else begin
            sync1_q      <= {btn_right, btn_left};
            sync2_q      <= sync1_q;
            stab_q       <= stab_d;
            cnt_q[0]     <= cnt_d[0];
            cnt_q[1]     <= cnt_d[1];
            vs_q         <= vsync;
            frame_tick_q <= tick;
            state_q      <= state_d;
            speed_q      <= speed_d;
            acc_q        <= acc_d;
            x_q          <= x_d;
        end
    end

    assign x_center   = x_q;
    assign dir        = state_q;
    assign speed      = speed_q;
    assign frame_tick = frame_tick_q;
    assign at_edge    = (x_q == 10'(X_MIN)) || (x_q == 10'(X_MAX));

endmodule

// File: tb/tb_figure_motion_ctrl.sv
// Directed bench for figure_motion_ctrl: one default instance plus two instances
// placed near the right and left limits, all driven by the same buttons and vsync.
module tb_figure_motion_ctrl;

    logic clk = 1'b0;
    logic reset, btn_left, btn_right, vsync;

    logic [9:0] xa, xb, xc;
    logic [1:0] da, db, dc;
    logic [2:0] sa, sb, sc;
    logic       ea, eb, ec;
    logic       ta, tb, tc;

    int checks = 0;
    int errors = 0;
    int tick_cnt = 0;

    always #5 clk = ~clk;

    figure_motion_ctrl dut_a (
        .clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right),
        .vsync(vsync), .x_center(xa), .dir(da), .speed(sa), .at_edge(ea), .frame_tick(ta)
    );

    figure_motion_ctrl #(.X_INIT(610), .X_MIN(20), .X_MAX(620)) dut_b (
        .clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right),
        .vsync(vsync), .x_center(xb), .dir(db), .speed(sb), .at_edge(eb), .frame_tick(tb)
    );

    figure_motion_ctrl #(.X_INIT(30), .X_MIN(20), .X_MAX(620)) dut_c (
        .clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right),
        .vsync(vsync), .x_center(xc), .dir(dc), .speed(sc), .at_edge(ec), .frame_tick(tc)
    );

    always @(negedge clk) if (ta === 1'b1) tick_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            @(negedge clk) vsync = 1'b0;
            repeat (4) @(negedge clk);
            vsync = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic set_btn(input logic l, input logic r);
        btn_left  = l;
        btn_right = r;
        repeat (20) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int t0;
        reset = 1'b1; btn_left = 1'b0; btn_right = 1'b0; vsync = 1'b1;
        do_reset();

        // 1: reset state and idle frames
        chk("rst_x", xa, 320);
        chk("rst_dir", da, 0);
        chk("rst_speed", sa, 0);
        chk("rst_edge", ea, 0);
        chk("rst_tick", ta, 0);
        chk("rst_x_b", xb, 610);
        t0 = tick_cnt;
        frames(3);
        chk("idle_ticks", tick_cnt - t0, 3);
        chk("idle_x", xa, 320);

        // 2: short glitch rejected, long press accepted
        @(negedge clk) btn_right = 1'b1;
        repeat (10) @(negedge clk);
        btn_right = 1'b0;
        repeat (20) @(negedge clk);
        frames(5);
        chk("glitch_x", xa, 320);
        chk("glitch_dir", da, 0);
        set_btn(1'b0, 1'b1);
        frames(1);
        chk("f1_x", xa, 321);
        chk("f1_dir", da, 2);
        chk("f1_speed", sa, 1);

        // 3/4: acceleration on dut_a, right clamp on dut_b
        frames(7);
        chk("f8_x", xa, 328);
        chk("f8_speed", sa, 2);
        chk("b_f8_x", xb, 618);
        chk("b_f8_edge", eb, 0);
        frames(1);
        chk("b_f9_x", xb, 620);
        chk("b_f9_edge", eb, 1);
        frames(1);
        chk("b_f10_x", xb, 620);
        chk("b_f10_speed", sb, 2);
        chk("b_f10_dir", db, 2);
        frames(6);
        chk("f16_x", xa, 344);
        chk("f16_speed", sa, 3);
        frames(4);
        chk("f20_x", xa, 356);
        chk("f20_speed", sa, 3);

        // 5: both pressed -> idle, then reversal to left
        set_btn(1'b1, 1'b1);
        frames(1);
        chk("both_dir", da, 0);
        chk("both_speed", sa, 0);
        chk("both_x", xa, 356);
        set_btn(1'b1, 1'b0);
        frames(1);
        chk("rev_dir", da, 1);
        chk("rev_speed", sa, 1);
        chk("rev_x", xa, 355);
        frames(31);
        chk("l32_x", xa, 276);
        chk("l32_speed", sa, 4);
        frames(8);
        chk("l40_x", xa, 244);
        chk("l40_speed", sa, 4);

        // 6: reset coincident with a frame tick
        btn_left = 1'b0; btn_right = 1'b1;
        do_reset();
        repeat (20) @(negedge clk);
        frames(14);
        chk("pre_x", xa, 340);
        chk("pre_speed", sa, 2);
        @(negedge clk);
        vsync = 1'b0;
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        chk("mid_rst_x", xa, 320);
        chk("mid_rst_speed", sa, 0);
        chk("mid_rst_dir", da, 0);
        chk("mid_rst_tick", ta, 0);
        repeat (3) @(negedge clk);
        vsync = 1'b1;
        repeat (20) @(negedge clk);
        frames(1);
        chk("post_rst_x", xa, 321);
        chk("post_rst_dir", da, 2);

        // 4 (mirror): left clamp on dut_c
        do_reset();
        set_btn(1'b1, 1'b0);
        frames(8);
        chk("c_f8_x", xc, 22);
        chk("c_f8_edge", ec, 0);
        frames(1);
        chk("c_f9_x", xc, 20);
        chk("c_f9_edge", ec, 1);
        frames(1);
        chk("c_f10_x", xc, 20);
        chk("c_f10_speed", sc, 2);
        chk("c_f10_dir", dc, 1);
        chk("a_f10_x", xa, 308);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
